// File: rtl/operand_fetch_arbiter_if.sv
// Requester, response and memory-port signals of the operand fetch arbiter.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface operand_fetch_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_data;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, mem_rdata,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_addr, busy
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_addr, busy
    );
endinterface

// File: rtl/operand_fetch_arbiter.sv
// Round-robin arbiter sharing one registered-output memory read port between
// the CPU operand fetch (port 0) and the debug/scan reader (port 1).
module operand_fetch_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_fetch_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

    logic grant0;
    logic grant1;

    // Port 0 wins a tie unless it was the last one served.
    always_comb begin
        grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1 = (state_q == IDLE) && bus.req1_valid && !grant0;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mem_addr_d   = mem_addr_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    mem_addr_d   = grant1 ? bus.req1_addr : bus.req0_addr;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                state_d = IDLE;
                if (owner_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_data_d  = bus.mem_rdata;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_data_d  = bus.mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so the first tie after reset goes to port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            mem_addr_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_operand_fetch_arbiter.sv
// Scoreboard bench for operand_fetch_arbiter: a cycle-level reference model
// predicts grants and response timing; a separate monitor checks responses.
module tb_operand_fetch_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_fetch_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    operand_fetch_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory model: registered output, one edge after the address is sampled.
    logic [7:0] rom [8];
    initial begin
        rom[0] = 8'hAB; rom[1] = 8'h69; rom[2] = 8'hC6; rom[3] = 8'h3C;
        rom[4] = 8'h91; rom[5] = 8'h67; rom[6] = 8'hCA; rom[7] = 8'h1D;
    end
    always @(posedge clk) bus.mem_rdata <= rom[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: when the port is free again, who was served last.
    typedef struct {
        bit         port;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         next_free;
    bit         last_g;
    logic [2:0] exp_mem_addr;
    logic [7:0] exp_data [2];

    bit         p0v, p1v;
    logic [2:0] p0a, p1a;
    bit         grant_log[$];

    task automatic model_reset();
        sb.delete();
        next_free    = 0;
        last_g       = 1'b1;
        exp_mem_addr = 3'd0;
        exp_data[0]  = 8'h00;
        exp_data[1]  = 8'h00;
    endtask

    // One cycle: drive inputs, compare the DUT handshake with the model's prediction.
    task automatic step(input bit v0, input logic [2:0] a0, input bit v1, input logic [2:0] a1,
                        output bit g0, output bit g1);
        bit idle;
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        #1;
        idle = (cyc >= next_free);
        g0   = idle && v0 && (!v1 || last_g);
        g1   = idle && v1 && !g0;
        check("req0_ready", bus.req0_ready, g0);
        check("req1_ready", bus.req1_ready, g1);
        check("busy", bus.busy, !idle);
        check("mem_addr", bus.mem_addr, exp_mem_addr);
        if (g0 || g1) begin
            exp_t e;
            e.port       = g1;
            e.data       = rom[g1 ? a1 : a0];
            e.due        = cyc + 3;
            sb.push_back(e);
            last_g       = g1;
            next_free    = cyc + 3;
            exp_mem_addr = g1 ? a1 : a0;
            grant_log.push_back(g1);
        end
    endtask

    task automatic step_pending();
        bit g0, g1;
        step(p0v, p0a, p1v, p1a, g0, g1);
        if (g0) p0v = 1'b0;
        if (g1) p1v = 1'b0;
    endtask

    task automatic serve_all(input string name);
        int n = 0;
        while ((p0v || p1v) && n < 60) begin
            step_pending();
            n++;
        end
        check({name, "_timeout"}, p0v | p1v, 1'b0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        p0v = 1'b0;
        p1v = 1'b0;
        while (sb.size() != 0 && n < 10) begin
            step_pending();
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due < cyc) begin
            check("rsp_missing", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            check("rsp_exclusive", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
            check("rsp_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_port", bus.rsp1_valid, e.port);
                check("rsp_data", e.port ? bus.rsp1_data : bus.rsp0_data, e.data);
                check("rsp_cycle", cyc, e.due);
                exp_data[e.port] = e.data;
            end
        end
        check("rsp0_data_hold", bus.rsp0_data, exp_data[0]);
        check("rsp1_data_hold", bus.rsp1_data, exp_data[1]);
    end

    initial begin
        bit g0, g1;
        int c0, c1;

        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 3'd0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 3'd0;
        p0v = 1'b0; p1v = 1'b0; p0a = 3'd0; p1a = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_mem_addr", bus.mem_addr, 3'd0);
        check("reset_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        rst_n = 1'b1;

        // Tie after reset: port 0 first (addr 5), then port 1 (addr 7).
        p0v = 1'b1; p0a = 3'd5; p1v = 1'b1; p1a = 3'd7;
        serve_all("tie");
        drain("tie");

        // Single read on port 0.
        p0v = 1'b1; p0a = 3'd2;
        serve_all("single");
        drain("single");

        // Fairness: both ports continuously valid for 12 grants.
        grant_log.delete();
        for (int n = 0; n < 200 && grant_log.size() < 12; n++) begin
            if (!p0v) begin p0v = 1'b1; p0a = 3'($urandom_range(7)); end
            if (!p1v) begin p1v = 1'b1; p1a = 3'($urandom_range(7)); end
            step_pending();
        end
        c0 = 0; c1 = 0;
        foreach (grant_log[i]) begin
            if (grant_log[i]) c1++; else c0++;
            if (i > 0) check("fair_alternate", grant_log[i], !grant_log[i-1]);
        end
        check("fair_count0", c0, 6);
        check("fair_count1", c1, 6);
        drain("fair");

        // Back-to-back on port 1 over all addresses.
        for (int a = 0; a < 8; a++) begin
            p1v = 1'b1; p1a = 3'(a);
            serve_all("stream");
        end
        drain("stream");

        // Reset while the read is in the ADDR state.
        p0v = 1'b1; p0a = 3'd4;
        serve_all("rst_accept");
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_mem_addr", bus.mem_addr, 3'd0);
        check("midrst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        check("midrst_rsp0_data", bus.rsp0_data, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0v = 1'b1; p0a = 3'd6;
        serve_all("post_rst");
        drain("post_rst");

        // Withdrawn request on port 1 during busy; last grant must stay with port 0.
        p0v = 1'b1; p0a = 3'd1;
        serve_all("wd_accept");
        step(1'b0, 3'd0, 1'b1, 3'd3, g0, g1);
        step(1'b0, 3'd0, 1'b0, 3'd3, g0, g1);
        drain("wd");
        p0v = 1'b1; p0a = 3'd0; p1v = 1'b1; p1a = 3'd3;
        step_pending();
        check("wd_tie_goes_to_port1", p1v, 1'b0);
        serve_all("wd_tie");
        drain("wd_tie");

        // Random traffic with random withdrawals.
        for (int n = 0; n < 600; n++) begin
            if (!p0v && ($urandom_range(2) == 0)) begin p0v = 1'b1; p0a = 3'($urandom_range(7)); end
            else if (p0v && ($urandom_range(9) == 0)) p0v = 1'b0;
            if (!p1v && ($urandom_range(2) == 0)) begin p1v = 1'b1; p1a = 3'($urandom_range(7)); end
            else if (p1v && ($urandom_range(9) == 0)) p1v = 1'b0;
            step_pending();
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
